// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// Holds the writeback-select and memory-op encodings, the RV32I load/store
// funct3 codes, the MEM stage FSM state type, the control half of the
// MEM/WB pipeline register, and a helper that flags misaligned accesses.
// Used by memory_access_cycle, load_store_align and the writeback stage.
package riscv_pkg;

    typedef enum logic [1:0] {
        WB_ALU      = 2'd0,
        WB_DATA_MEM = 2'd1,
        WB_PC       = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_op_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Control fields of the MEM/WB register; the XLEN-wide data fields
    // live beside it in the stage so the struct stays width-independent.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] rd;
        wb_sel_t    wb_sel;
        logic       misaligned;
    } mem_wb_ctrl_t;

    // funct3[1:0] gives the access size: 00 byte, 01 half, 1x word.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic result;
        case (funct3[1:0])
            F3_SB[1:0]: result = 1'b0;
            F3_SH[1:0]: result = offset[0];
            default:    result = (offset != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic for the MEM stage.
// Ports:
//   offset     in  2     byte offset within the word (addr[1:0])
//   funct3     in  3     RV32I load/store width code
//   store_data in  XLEN  rs2 value
//   load_raw   in  XLEN  raw word returned by data memory
//   be         out XLEN/8 byte enables for a store
//   wdata      out XLEN  store data replicated across lanes
//   misaligned out 1     access does not fit its natural alignment
//   load_data  out XLEN  selected and sign/zero-extended load result
module load_store_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_raw,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic              misaligned,
    output logic [XLEN-1:0]   load_data
);

    localparam int BEW = XLEN / 8;

    logic [XLEN-1:0] shifted;

    // Bring the addressed lane down to bit 0; an aligned word has offset 0,
    // so the same shift serves LW as well.
    assign shifted    = load_raw >> {offset, 3'b000};
    assign misaligned = is_misaligned(funct3, offset);

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        be    = '0;
        wdata = store_data;
        case (funct3[1:0])
            F3_SB[1:0]: begin
                be    = BEW'(1) << offset;
                wdata = {BEW{store_data[7:0]}};
            end
            F3_SH[1:0]: begin
                be    = BEW'(3) << offset;
                wdata = {(XLEN/16){store_data[15:0]}};
            end
            default: begin
                be    = BEW'(15);
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:   load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH:   load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_cycle.sv
// MEM stage of the 5-stage RISC-V pipeline.
// Accepts one EX/MEM entry at a time, runs a load/store on data memory via a
// req/ack handshake, aligns/extends load data and registers the MEM/WB entry.
// Optional build macro MEM_STAGE_TIMEOUT_EN: aborts an access after
// TIMEOUT_CYCLES cycles without ack and adds the bus_err_exc output.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex_valid / ex_ready         EX/MEM handshake (ready only in IDLE)
//   ex_alu_result .. ex_wb_sel  EX/MEM entry fields
//   dm_req/we/addr/wdata/be     data memory request, held until dm_ack
//   dm_rdata, dm_ack            data memory response
//   writeback_data_sel, alu_data_out, writeback_PC, dm_read_data,
//   wb_rd, wb_reg_write, wb_valid, misaligned_exc   MEM/WB register
//   bus_err_exc                 (timeout build only) aborted access pulse
module memory_access_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [1:0]        ex_mem_op,
    input  logic [2:0]        ex_funct3,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic [1:0]        ex_wb_sel,
    output logic              dm_req,
    output logic              dm_we,
    output logic [XLEN-1:0]   dm_addr,
    output logic [XLEN-1:0]   dm_wdata,
    output logic [XLEN/8-1:0] dm_be,
    input  logic [XLEN-1:0]   dm_rdata,
    input  logic              dm_ack,
    output logic [1:0]        writeback_data_sel,
    output logic [XLEN-1:0]   alu_data_out,
    output logic [XLEN-1:0]   writeback_PC,
    output logic [XLEN-1:0]   dm_read_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              wb_valid,
`ifdef MEM_STAGE_TIMEOUT_EN
    output logic              bus_err_exc,
`endif
    output logic              misaligned_exc
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_t   state, next_state;
    mem_op_t      op;
    mem_wb_ctrl_t wb_ctrl;

    logic        in_access, accept, is_mem, start_access, ack_hit, abort;
    logic [XLEN-1:0] req_alu, req_pc;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        req_reg_write;
    wb_sel_t     req_wb_sel;

    logic [1:0]        al_offset;
    logic [2:0]        al_funct3;
    logic [XLEN/8-1:0] al_be;
    logic [XLEN-1:0]   al_wdata, al_load_data;
    logic              al_misaligned;

    assign op        = mem_op_t'(ex_mem_op);
    assign in_access = (state == ACCESS);
    assign is_mem    = (op == MEM_LOAD) || (op == MEM_STORE);
    assign accept    = ex_valid && ex_ready;
    assign start_access = accept && is_mem && !al_misaligned;
    assign ack_hit   = in_access && dm_ack;

    // One aligner serves both phases: in IDLE it sizes the incoming entry,
    // in ACCESS it extracts load data using the captured offset/funct3.
    assign al_offset = in_access ? req_alu[1:0] : ex_alu_result[1:0];
    assign al_funct3 = in_access ? req_funct3   : ex_funct3;

    load_store_align #(.XLEN(XLEN)) u_align (
        .offset     (al_offset),
        .funct3     (al_funct3),
        .store_data (ex_store_data),
        .load_raw   (dm_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .misaligned (al_misaligned),
        .load_data  (al_load_data)
    );

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Counts ACCESS cycles; held at zero in IDLE so each access starts fresh.
    always_ff @(posedge clk) begin
        if (rst || !in_access) tmo_cnt <= '0;
        else                   tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign abort = in_access && !dm_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ex_ready   = 1'b0;
        dm_req     = 1'b0;
        case (state)
            IDLE: begin
                ex_ready = 1'b1;
                if (start_access) next_state = ACCESS;
            end
            ACCESS: begin
                dm_req = 1'b1;
                if (ack_hit || abort) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request register: drives the memory port unchanged for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            dm_addr       <= '0;
            dm_wdata      <= '0;
            dm_be         <= '0;
            dm_we         <= 1'b0;
            req_alu       <= '0;
            req_pc        <= '0;
            req_funct3    <= '0;
            req_rd        <= '0;
            req_reg_write <= 1'b0;
            req_wb_sel    <= WB_ALU;
        end else if (start_access) begin
            dm_addr       <= {ex_alu_result[XLEN-1:2], 2'b00};
            dm_wdata      <= al_wdata;
            dm_be         <= al_be;
            dm_we         <= (op == MEM_STORE);
            req_alu       <= ex_alu_result;
            req_pc        <= ex_pc;
            req_funct3    <= ex_funct3;
            req_rd        <= ex_rd;
            req_reg_write <= ex_reg_write;
            req_wb_sel    <= wb_sel_t'(ex_wb_sel);
        end
    end

    // MEM/WB register. Pulse fields clear every cycle; data fields hold
    // through bubbles and load only when an entry completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctrl      <= '0;
            alu_data_out <= '0;
            writeback_PC <= '0;
            dm_read_data <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
            bus_err_exc  <= 1'b0;
`endif
        end else begin
            wb_ctrl.valid      <= 1'b0;
            wb_ctrl.reg_write  <= 1'b0;
            wb_ctrl.misaligned <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            bus_err_exc        <= 1'b0;
`endif
            if (accept && !start_access) begin
                // Non-memory entry or misaligned access: completes in one cycle.
                wb_ctrl.valid      <= 1'b1;
                wb_ctrl.reg_write  <= ex_reg_write && !(is_mem && al_misaligned)
                                      && (op != MEM_STORE);
                wb_ctrl.misaligned <= is_mem && al_misaligned;
                wb_ctrl.rd         <= ex_rd;
                wb_ctrl.wb_sel     <= wb_sel_t'(ex_wb_sel);
                alu_data_out       <= ex_alu_result;
                writeback_PC       <= ex_pc;
                dm_read_data       <= '0;
            end else if (ack_hit || abort) begin
                wb_ctrl.valid      <= 1'b1;
                wb_ctrl.reg_write  <= req_reg_write && !dm_we && !abort;
                wb_ctrl.rd         <= req_rd;
                wb_ctrl.wb_sel     <= req_wb_sel;
                alu_data_out       <= req_alu;
                writeback_PC       <= req_pc;
                dm_read_data       <= (dm_we || abort) ? '0 : al_load_data;
`ifdef MEM_STAGE_TIMEOUT_EN
                bus_err_exc        <= abort;
`endif
            end
        end
    end

    assign writeback_data_sel = wb_ctrl.wb_sel;
    assign wb_rd              = wb_ctrl.rd;
    assign wb_reg_write       = wb_ctrl.reg_write;
    assign wb_valid           = wb_ctrl.valid;
    assign misaligned_exc     = wb_ctrl.misaligned;

endmodule

// File: tb/tb_memory_access_cycle.sv
// Self-checking bench for memory_access_cycle: directed cases followed by
// randomized transactions compared against a behavioural lane/extension model.
module tb_memory_access_cycle;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, ex_ready;
    logic [XLEN-1:0] ex_alu_result, ex_store_data, ex_pc;
    logic [1:0]      ex_mem_op;
    logic [2:0]      ex_funct3;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic [1:0]      ex_wb_sel;
    logic            dm_req, dm_we;
    logic [XLEN-1:0] dm_addr, dm_wdata;
    logic [3:0]      dm_be;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_ack;
    logic [1:0]      writeback_data_sel;
    logic [XLEN-1:0] alu_data_out, writeback_PC, dm_read_data;
    logic [4:0]      wb_rd;
    logic            wb_reg_write, wb_valid, misaligned_exc;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic            bus_err_exc;
`endif

    int errors = 0;
    int checks = 0;

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    memory_access_cycle #(.XLEN(XLEN), .TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_valid           (ex_valid),
        .ex_ready           (ex_ready),
        .ex_alu_result      (ex_alu_result),
        .ex_store_data      (ex_store_data),
        .ex_pc              (ex_pc),
        .ex_mem_op          (ex_mem_op),
        .ex_funct3          (ex_funct3),
        .ex_rd              (ex_rd),
        .ex_reg_write       (ex_reg_write),
        .ex_wb_sel          (ex_wb_sel),
        .dm_req             (dm_req),
        .dm_we              (dm_we),
        .dm_addr            (dm_addr),
        .dm_wdata           (dm_wdata),
        .dm_be              (dm_be),
        .dm_rdata           (dm_rdata),
        .dm_ack             (dm_ack),
        .writeback_data_sel (writeback_data_sel),
        .alu_data_out       (alu_data_out),
        .writeback_PC       (writeback_PC),
        .dm_read_data       (dm_read_data),
        .wb_rd              (wb_rd),
        .wb_reg_write       (wb_reg_write),
        .wb_valid           (wb_valid),
`ifdef MEM_STAGE_TIMEOUT_EN
        .bus_err_exc        (bus_err_exc),
`endif
        .misaligned_exc     (misaligned_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // All stimulus changes and output samples happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = size_bytes(f3);
        return ((32'd1 << n) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
        case (size_bytes(f3))
            1:       return (data & 32'hFF) * 32'h0101_0101;
            2:       return (data & 32'hFFFF) * 32'h0001_0001;
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v = rdata >> (8 * (addr % 4));
        case (f3)
            3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'b100:       v = v & 32'hFF;
            3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'b101:       v = v & 32'hFFFF;
            default:      v = rdata;
        endcase
        return v;
    endfunction

    // Drives one entry and follows it to completion. delay = number of ACCESS
    // cycles dm_req is expected to be held (ack arrives in the last of them).
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] pc, input logic [4:0] rd, input logic regw,
                           input logic [1:0] wbsel, input int delay, input logic [31:0] rdata);
        bit is_mem   = (op == 2'd1) || (op == 2'd2);
        bit is_store = (op == 2'd2);
        bit mis      = is_mem && ((addr % size_bytes(f3)) != 0);
        bit exp_wr   = regw && !mis && !is_store;

        check({tag, "_ready"}, ex_ready, 1'b1);
        ex_valid = 1'b1; ex_mem_op = op; ex_funct3 = f3; ex_alu_result = addr;
        ex_store_data = data; ex_pc = pc; ex_rd = rd; ex_reg_write = regw; ex_wb_sel = wbsel;
        tick();
        ex_valid = 1'b0; ex_alu_result = $urandom; ex_store_data = $urandom;
        ex_pc = $urandom; ex_rd = 5'($urandom); ex_funct3 = 3'($urandom);

        if (is_mem && !mis) begin
            for (int k = 1; k <= delay; k++) begin
                check({tag, "_req"},      dm_req, 1'b1);
                check({tag, "_ready_lo"}, ex_ready, 1'b0);
                check({tag, "_we"},       dm_we, is_store);
                check({tag, "_addr"},     dm_addr, addr & 32'hFFFF_FFFC);
                check({tag, "_wbv_lo"},   wb_valid, 1'b0);
                if (is_store) begin
                    check({tag, "_be"},    dm_be, model_be(f3, addr));
                    check({tag, "_wdata"}, dm_wdata, model_wdata(f3, data));
                end
                dm_ack   = (k == delay);
                dm_rdata = (k == delay) ? rdata : $urandom;
                tick();
                dm_ack   = 1'b0;
                dm_rdata = $urandom;
            end
        end else begin
            check({tag, "_noreq"}, dm_req, 1'b0);
        end

        check({tag, "_wbv"},    wb_valid, 1'b1);
        check({tag, "_wbwr"},   wb_reg_write, exp_wr);
        check({tag, "_mis"},    misaligned_exc, mis);
        check({tag, "_rd"},     wb_rd, rd);
        check({tag, "_alu"},    alu_data_out, addr);
        check({tag, "_pc"},     writeback_PC, pc);
        check({tag, "_sel"},    writeback_data_sel, wbsel);
        check({tag, "_req_lo"}, dm_req, 1'b0);
        if (!is_mem)
            check({tag, "_rdata0"}, dm_read_data, 32'h0);
        else if (!is_store && !mis)
            check({tag, "_ldata"}, dm_read_data, model_load(f3, addr, rdata));
    endtask

    // Bubble cycle with a stray ack: nothing must issue and data fields hold.
    task automatic idle_cycle(input logic [31:0] held_alu);
        dm_ack = 1'($urandom);
        tick();
        dm_ack = 1'b0;
        check("bubble_wbv",  wb_valid, 1'b0);
        check("bubble_wbwr", wb_reg_write, 1'b0);
        check("bubble_mis",  misaligned_exc, 1'b0);
        check("bubble_req",  dm_req, 1'b0);
        check("bubble_hold", alu_data_out, held_alu);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_pc = '0;
        ex_mem_op = '0; ex_funct3 = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_wb_sel = '0;
        dm_rdata = '0; dm_ack = 1'b0;
        tick(); tick();
        check("rst_req",   dm_req, 1'b0);
        check("rst_we",    dm_we, 1'b0);
        check("rst_addr",  dm_addr, 32'h0);
        check("rst_be",    dm_be, 4'h0);
        check("rst_wbv",   wb_valid, 1'b0);
        check("rst_alu",   alu_data_out, 32'h0);
        check("rst_mis",   misaligned_exc, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_ready", ex_ready, 1'b1);

        // Directed cases
        run_txn("alu", 2'd0, 3'b000, 32'h0000_1234, 32'h0, 32'h40, 5'd5, 1'b1, 2'd0, 0, 32'h0);
        idle_cycle(32'h0000_1234);
        run_txn("lb",  2'd1, 3'b000, 32'h0000_0103, 32'h0, 32'h44, 5'd6, 1'b1, 2'd1, 3, 32'h80FF_FFFF);
        check("lb_value", dm_read_data, 32'hFFFF_FF80);
        run_txn("lbu", 2'd1, 3'b100, 32'h0000_0103, 32'h0, 32'h48, 5'd7, 1'b1, 2'd1, 1, 32'h80FF_FFFF);
        check("lbu_value", dm_read_data, 32'h0000_0080);
        run_txn("sh",  2'd2, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h4C, 5'd8, 1'b1, 2'd0, 2, 32'h0);
        run_txn("lwmis", 2'd1, 3'b010, 32'h0000_0101, 32'h0, 32'h50, 5'd9, 1'b1, 2'd1, 1, 32'h0);
        run_txn("rsvd", 2'd3, 3'b010, 32'h0000_0055, 32'h0, 32'h54, 5'd10, 1'b1, 2'd2, 0, 32'h0);

        // Reset in the second ACCESS cycle, with a late ack afterwards
        ex_valid = 1'b1; ex_mem_op = 2'd1; ex_funct3 = 3'b010; ex_alu_result = 32'h300;
        ex_rd = 5'd11; ex_reg_write = 1'b1;
        tick();
        ex_valid = 1'b0;
        tick();
        check("rstacc_req_hi", dm_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstacc_req_lo", dm_req, 1'b0);
        check("rstacc_wbv",    wb_valid, 1'b0);
        check("rstacc_ready",  ex_ready, 1'b1);
        dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        tick();
        dm_ack = 1'b0;
        check("late_ack_wbv", wb_valid, 1'b0);
        check("late_ack_req", dm_req, 1'b0);

`ifdef MEM_STAGE_TIMEOUT_EN
        // No ack: abort after 4 ACCESS cycles
        ex_valid = 1'b1; ex_mem_op = 2'd1; ex_funct3 = 3'b010; ex_alu_result = 32'h400;
        ex_rd = 5'd12; ex_reg_write = 1'b1;
        tick();
        ex_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("tmo_req", dm_req, 1'b1);
            check("tmo_err_lo", bus_err_exc, 1'b0);
            tick();
        end
        check("tmo_req_lo", dm_req, 1'b0);
        check("tmo_wbv",    wb_valid, 1'b1);
        check("tmo_err",    bus_err_exc, 1'b1);
        check("tmo_wbwr",   wb_reg_write, 1'b0);
        tick();
        check("tmo_err_pulse", bus_err_exc, 1'b0);
`endif

        // Randomized transactions
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  op    = 2'($urandom_range(0, 3));
            logic [2:0]  f3    = 3'($urandom);
            logic [31:0] addr  = $urandom;
            logic [31:0] data  = $urandom;
            logic [31:0] pc    = $urandom;
            logic [31:0] rdata = $urandom;
            int          delay = $urandom_range(1, 4);
            if (op == 2'd1) f3 = ld_f3[$urandom_range(0, 4)];
            if (op == 2'd2) f3 = st_f3[$urandom_range(0, 2)];
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'(size_bytes(f3) - 1);
            run_txn("rand", op, f3, addr, data, pc, 5'($urandom), 1'($urandom),
                    2'($urandom_range(0, 2)), delay, rdata);
            if ($urandom_range(0, 2) == 0) idle_cycle(addr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_access_cycle.md
Name: memory_access_cycle

Overview:
- MEM stage of the 5-stage RISC-V pipeline. Sits between execute and the writeback mux.
- Accepts one EX/MEM entry at a time and performs a load or store on the data memory through a req/ack handshake.
- Aligns and extends load data, then registers the result into the MEM/WB pipeline register consumed by writeback.
- Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath/address width; multiple of 8.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with MEM_STAGE_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM entry present
- ex_ready  out  1  stage can accept entry this cycle
- ex_alu_result  in  XLEN  ALU result / effective address
- ex_store_data  in  XLEN  rs2 value for stores
- ex_pc  in  XLEN  instruction PC
- ex_mem_op  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none)
- ex_funct3  in  3  RV32I load/store width code
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_wb_sel  in  2  0 ALU, 1 DATA_MEM, 2 PC
- dm_req  out  1  memory request, held until ack
- dm_we  out  1  1 = store
- dm_addr  out  XLEN  word-aligned address (low 2 bits zero)
- dm_wdata  out  XLEN  lane-shifted store data
- dm_be  out  XLEN/8  byte enables
- dm_rdata  in  XLEN  read data, valid with dm_ack
- dm_ack  in  1  access complete
- writeback_data_sel  out  2  registered ex_wb_sel
- alu_data_out  out  XLEN  registered ALU result
- writeback_PC  out  XLEN  registered PC (writeback adds 4)
- dm_read_data  out  XLEN  registered, extended load data
- wb_rd  out  5  registered rd
- wb_reg_write  out  1  qualified register write
- wb_valid  out  1  MEM/WB entry valid, one cycle per instruction
- misaligned_exc  out  1  one-cycle pulse with the faulting entry's wb_valid

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE.
- FSM states: IDLE, ACCESS.
- ex_ready = (state == IDLE). An entry is accepted when ex_valid && ex_ready.
- Non-memory entry (op 0 or 3): MEM/WB register loaded next edge; latency 1. dm_read_data = 0.
- Memory entry, aligned: IDLE -> ACCESS. Address, data, be and op are captured in a request register.
  - dm_req = 1 throughout ACCESS; dm_addr, dm_wdata, dm_be and dm_we stay stable.
- ACCESS with dm_ack: the MEM/WB register is loaded and the FSM returns to IDLE.
  - Minimum load/store latency is 2 cycles (ack in the first ACCESS cycle).
  - The next entry is accepted in the cycle after ack.
- dm_ack in IDLE is ignored.
- Byte lanes: offset = addr[1:0].
  - SB: be = 1 << offset, data replicated to all lanes.
  - SH: be = 0b11 << offset, data replicated in halves.
  - SW: be = 0b1111.
- Load extraction: select a byte or halfword by offset.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
  - Captured from dm_rdata on the ack cycle.
- Misaligned (halfword with addr[0] = 1, or word with addr[1:0] != 0):
  - No dm_req is issued; latency is 1.
  - wb_valid = 1, wb_reg_write = 0, misaligned_exc = 1.
- Stores: wb_reg_write = 0 regardless of ex_reg_write.
- wb_reg_write = ex_reg_write && wb_valid && no exception.
- Bubble cycles: wb_valid = 0 and wb_reg_write = 0; other MEM/WB fields hold their previous values.
- Reset mid-ACCESS: dm_req drops the next edge. Any late ack is ignored and the entry is discarded.

Optional Feature:
- Macro: MEM_STAGE_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in ACCESS and clears on entry to ACCESS.
  - If TIMEOUT_CYCLES elapse without dm_ack, the access aborts: dm_req drops and the FSM returns to IDLE.
  - The MEM/WB entry is written with wb_valid = 1 and wb_reg_write = 0, and an extra output bus_err_exc pulses for one cycle.
- Disabled: no counter and no bus_err_exc port; ACCESS waits indefinitely.

Decomposition:
- Shared package riscv_pkg holds:
  - wb_sel enum (ALU = 0, DATA_MEM = 1, PC = 2), also used by the writeback stage.
  - mem_op enum.
  - funct3 load/store constants (LB = 000, LH = 001, LW = 010, LBU = 100, LHU = 101, SB = 000, SH = 001, SW = 010).
  - An MEM/WB struct type.
- One combinational sub-module, load_store_align, produces be, shifted wdata, misaligned flag and extended load data.

Test Plan:
- ALU op, result 0x0000_1234, wb_sel = 0, rd = 5 -> next cycle wb_valid = 1, alu_data_out = 0x1234, wb_rd = 5, no dm_req.
- LB at 0x103, ack after 3 cycles with dm_rdata = 0x80FF_FFFF -> dm_addr = 0x100, dm_req held 3 cycles, ex_ready = 0 throughout, dm_read_data = 0xFFFF_FF80. LBU on the same data gives 0x0000_0080.
- SH of 0x0000_ABCD at 0x202 -> dm_addr = 0x200, dm_be = 0b1100, dm_wdata = 0xABCD_ABCD, dm_we = 1, wb_reg_write = 0.
- LW at 0x101 -> no dm_req, misaligned_exc = 1, wb_valid = 1, wb_reg_write = 0, latency 1.
- rst asserted in the second ACCESS cycle, ack arrives the cycle after -> dm_req = 0 after the edge, wb_valid stays 0, FSM in IDLE.
- MEM_STAGE_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no ack -> abort after 4 cycles, bus_err_exc = 1, wb_reg_write = 0.
